atm_session_ctrl: RTL and testbench



---
 rtl/atm_session_ctrl_pkg.sv | 30 +++
 rtl/atm_session_ctrl_if.sv | 37 +++
 rtl/atm_session_ctrl_session_timer.sv | 27 ++
 rtl/atm_session_ctrl.sv | 174 +++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_session_ctrl_pkg.sv
// Shared encodings for the ATM session sequencer: FSM states, error codes and menu operations.
package atm_session_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WAIT_PIN  = 3'd2,
        CHECK_PIN = 3'd3,
        MENU      = 3'd4,
        EXEC      = 3'd5,
        EJECT     = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_NOT_FOUND = 3'd1,
        ERR_BAD_PIN   = 3'd2,
        ERR_LOCKED    = 3'd3,
        ERR_TIMEOUT   = 3'd4,
        ERR_REMOVED   = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        OP_BALANCE  = 2'd0,
        OP_WITHDRAW = 2'd1,
        OP_DEPOSIT  = 2'd2,
        OP_EXIT     = 2'd3
    } op_e;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Session bus between the card/keypad front end, the authenticator, the transaction datapath
// and the session sequencer. The sequencer uses the slave view; the environment uses master.
interface atm_session_ctrl_if;
    logic        card_in;
    logic [3:0]  acc_num;
    logic        pin_valid;
    logic [15:0] pin;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        auth_found;
    logic        auth_ok;
    logic [3:0]  auth_index;
    logic        op_done;
    logic [3:0]  auth_acc_num;
    logic [15:0] auth_pin;
    logic        op_req;
    logic [1:0]  op_sel;
    logic [3:0]  acc_index;
    logic        session_active;
    logic        eject;
    logic [2:0]  err_code;
    logic [2:0]  state_out;

    modport slave (
        input  card_in, acc_num, pin_valid, pin, op_valid, op_code,
               auth_found, auth_ok, auth_index, op_done,
        output auth_acc_num, auth_pin, op_req, op_sel, acc_index,
               session_active, eject, err_code, state_out
    );

    modport master (
        output card_in, acc_num, pin_valid, pin, op_valid, op_code,
               auth_found, auth_ok, auth_index, op_done,
        input  auth_acc_num, auth_pin, op_req, op_sel, acc_index,
               session_active, eject, err_code, state_out
    );
endinterface

// File: rtl/atm_session_ctrl_session_timer.sv
// Inactivity counter: counts while run is high, restarts on clear, flags the last allowed idle cycle.
module session_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == LAST);
endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card-session sequencer: account lookup, PIN check with per-account lockout,
// inactivity timeout and menu dispatch over an op_req/op_done handshake.
module atm_session_ctrl
    import atm_session_ctrl_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned NUM_ACCOUNTS   = 10
) (
    input logic               clk,
    input logic               rst,
    atm_session_ctrl_if.slave bus
);
    state_e                  state_q, state_d;
    err_e                    err_q, err_d;
    logic [3:0]              acc_num_q, acc_num_d;
    logic [15:0]             pin_q, pin_d;
    logic [1:0]              op_sel_q, op_sel_d;
    logic [3:0]              acc_index_q, acc_index_d;
    logic [2:0]              tries_q, tries_d;
    logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
    logic                    op_req_q, op_req_d;
    logic                    eject_q, eject_d;
    logic                    active_q, active_d;
    logic                    timer_run, timer_clear, timer_expired;

    session_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    assign timer_run = (state_q == WAIT_PIN) || (state_q == MENU);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        acc_num_d   = acc_num_q;
        pin_d       = pin_q;
        op_sel_d    = op_sel_q;
        acc_index_d = acc_index_q;
        tries_d     = tries_q;
        lock_d      = lock_q;
        case (state_q)
            IDLE: begin
                if (bus.card_in) begin
                    acc_num_d = bus.acc_num;
                    err_d     = ERR_NONE;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!bus.card_in) begin
                    err_d   = ERR_REMOVED;
                    state_d = IDLE;
                end else if (!bus.auth_found || 32'(bus.auth_index) >= NUM_ACCOUNTS) begin
                    err_d   = ERR_NOT_FOUND;
                    state_d = EJECT;
                end else if (lock_q[bus.auth_index]) begin
                    err_d   = ERR_LOCKED;
                    state_d = EJECT;
                end else begin
                    acc_index_d = bus.auth_index;
                    tries_d     = '0;
                    state_d     = WAIT_PIN;
                end
            end
            WAIT_PIN: begin
                if (!bus.card_in) begin
                    err_d   = ERR_REMOVED;
                    state_d = IDLE;
                end else if (bus.pin_valid) begin
                    pin_d   = bus.pin;
                    state_d = CHECK_PIN;
                end else if (timer_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = EJECT;
                end
            end
            CHECK_PIN: begin
                if (!bus.card_in) begin
                    err_d   = ERR_REMOVED;
                    state_d = IDLE;
                end else if (bus.auth_ok) begin
                    tries_d = '0;
                    err_d   = ERR_NONE;
                    state_d = MENU;
                end else if ((tries_q + 3'd1) == 3'(MAX_TRIES)) begin
                    lock_d[acc_index_q] = 1'b1;
                    err_d   = ERR_LOCKED;
                    state_d = EJECT;
                end else begin
                    tries_d = tries_q + 3'd1;
                    err_d   = ERR_BAD_PIN;
                    state_d = WAIT_PIN;
                end
            end
            MENU: begin
                if (!bus.card_in) begin
                    err_d   = ERR_REMOVED;
                    state_d = IDLE;
                end else if (bus.op_valid) begin
                    if (bus.op_code == OP_EXIT) begin
                        state_d = EJECT;
                    end else begin
                        op_sel_d = bus.op_code;
                        state_d  = EXEC;
                    end
                end else if (timer_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = EJECT;
                end
            end
            // Card removal is deliberately not checked here; MENU picks it up after op_done.
            EXEC: begin
                if (bus.op_done) begin
                    state_d = MENU;
                end
            end
            EJECT: begin
                if (!bus.card_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with state_out.
        op_req_d    = (state_d == EXEC);
        eject_d     = (state_d == EJECT);
        active_d    = (state_d == MENU) || (state_d == EXEC);
        timer_clear = (state_d != state_q) || bus.pin_valid || bus.op_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            err_q       <= ERR_NONE;
            acc_num_q   <= '0;
            pin_q       <= '0;
            op_sel_q    <= '0;
            acc_index_q <= '0;
            tries_q     <= '0;
            lock_q      <= '0;
            op_req_q    <= 1'b0;
            eject_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            acc_num_q   <= acc_num_d;
            pin_q       <= pin_d;
            op_sel_q    <= op_sel_d;
            acc_index_q <= acc_index_d;
            tries_q     <= tries_d;
            lock_q      <= lock_d;
            op_req_q    <= op_req_d;
            eject_q     <= eject_d;
            active_q    <= active_d;
        end
    end

    assign bus.auth_acc_num   = acc_num_q;
    assign bus.auth_pin       = pin_q;
    assign bus.op_req         = op_req_q;
    assign bus.op_sel         = op_sel_q;
    assign bus.acc_index      = acc_index_q;
    assign bus.session_active = active_q;
    assign bus.eject          = eject_q;
    assign bus.err_code       = err_q;
    assign bus.state_out      = state_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic, all checked against a session-level reference model.
module tb_atm_session_ctrl;
    localparam int unsigned MAX_TRIES      = 3;
    localparam int unsigned TIMEOUT_CYCLES = 1000;
    localparam int unsigned NUM_ACCOUNTS   = 10;

    localparam int P_IDLE = 0, P_LOOKUP = 1, P_WAIT = 2, P_CHECK = 3, P_MENU = 4, P_EXEC = 5, P_EJECT = 6;
    localparam int E_NONE = 0, E_NOT_FOUND = 1, E_BAD_PIN = 2, E_LOCKED = 3, E_TIMEOUT = 4, E_REMOVED = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atm_session_ctrl_if bus();

    atm_session_ctrl #(
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NUM_ACCOUNTS   (NUM_ACCOUNTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Card database shared by the authenticator stub and the reference model.
    function automatic void card_db(input logic [3:0] a, output logic f, output logic [3:0] idx,
                                    output logic [15:0] p);
        f = 1'b1;
        case (a)
            4'd1:    begin idx = 4'd0;  p = 16'h1234; end
            4'd3:    begin idx = 4'd2;  p = 16'h3456; end
            4'd5:    begin idx = 4'd4;  p = 16'h5555; end
            4'd7:    begin idx = 4'd6;  p = 16'h7777; end
            4'd9:    begin idx = 4'd12; p = 16'h9999; end
            default: begin f = 1'b0; idx = 4'd15; p = 16'h0000; end
        endcase
    endfunction

    logic        db_f;
    logic [3:0]  db_idx;
    logic [15:0] db_p;
    always_comb begin
        card_db(bus.auth_acc_num, db_f, db_idx, db_p);
        bus.auth_found = db_f;
        bus.auth_index = db_idx;
        bus.auth_ok    = db_f && (bus.auth_pin == db_p);
    end

    // Reference model of the session.
    int          m_phase, m_err, m_wrong, m_idle;
    logic [3:0]  m_acc, m_idx;
    logic [15:0] m_pin;
    logic [1:0]  m_op;
    bit   [15:0] m_locked;

    task automatic model_reset();
        m_phase = P_IDLE; m_err = E_NONE; m_wrong = 0; m_idle = 0;
        m_acc = '0; m_idx = '0; m_pin = '0; m_op = '0; m_locked = '0;
    endtask

    task automatic tick_idle();
        if (m_idle + 1 == int'(TIMEOUT_CYCLES)) begin
            m_err = E_TIMEOUT; m_phase = P_EJECT;
        end else begin
            m_idle++;
        end
    endtask

    task automatic model_step();
        logic f; logic [3:0] idx; logic [15:0] p;
        card_db(m_acc, f, idx, p);
        if (!bus.card_in && (m_phase == P_LOOKUP || m_phase == P_WAIT ||
                             m_phase == P_CHECK || m_phase == P_MENU)) begin
            m_err = E_REMOVED; m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (bus.card_in) begin
                    m_acc = bus.acc_num; m_err = E_NONE; m_phase = P_LOOKUP;
                end
                P_LOOKUP: begin
                    if (!f || int'(idx) >= int'(NUM_ACCOUNTS)) begin
                        m_err = E_NOT_FOUND; m_phase = P_EJECT;
                    end else if (m_locked[idx]) begin
                        m_err = E_LOCKED; m_phase = P_EJECT;
                    end else begin
                        m_idx = idx; m_wrong = 0; m_idle = 0; m_phase = P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (bus.pin_valid) begin m_pin = bus.pin; m_phase = P_CHECK; end
                    else tick_idle();
                end
                P_CHECK: begin
                    if (f && m_pin == p) begin
                        m_wrong = 0; m_err = E_NONE; m_idle = 0; m_phase = P_MENU;
                    end else if (m_wrong + 1 == int'(MAX_TRIES)) begin
                        m_locked[m_idx] = 1'b1; m_err = E_LOCKED; m_phase = P_EJECT;
                    end else begin
                        m_wrong++; m_err = E_BAD_PIN; m_idle = 0; m_phase = P_WAIT;
                    end
                end
                P_MENU: begin
                    if (bus.op_valid) begin
                        if (bus.op_code == 2'd3) m_phase = P_EJECT;
                        else begin m_op = bus.op_code; m_phase = P_EXEC; end
                    end else begin
                        tick_idle();
                    end
                end
                P_EXEC: if (bus.op_done) begin m_idle = 0; m_phase = P_MENU; end
                P_EJECT: if (!bus.card_in) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        expect_eq("state_out",      32'(bus.state_out),      32'(m_phase));
        expect_eq("err_code",       32'(bus.err_code),       32'(m_err));
        expect_eq("session_active", 32'(bus.session_active), 32'(m_phase == P_MENU || m_phase == P_EXEC));
        expect_eq("eject",          32'(bus.eject),          32'(m_phase == P_EJECT));
        expect_eq("op_req",         32'(bus.op_req),         32'(m_phase == P_EXEC));
        expect_eq("op_sel",         32'(bus.op_sel),         32'(m_op));
        expect_eq("acc_index",      32'(bus.acc_index),      32'(m_idx));
        expect_eq("auth_acc_num",   32'(bus.auth_acc_num),   32'(m_acc));
        expect_eq("auth_pin",       32'(bus.auth_pin),       32'(m_pin));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic card, input logic [3:0] acc, input logic pv, input logic [15:0] pn,
                         input logic ov, input logic [1:0] oc, input logic od);
        bus.card_in = card; bus.acc_num = acc; bus.pin_valid = pv; bus.pin = pn;
        bus.op_valid = ov; bus.op_code = oc; bus.op_done = od;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst = 1'b1;
        model_reset();
        #2;
        expect_eq("rst.op_req", 32'(bus.op_req), 32'd0);
        expect_eq("rst.eject",  32'(bus.eject),  32'd0);
        compare_model();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        card_in;
        logic [3:0]  acc_num;
        logic        pin_valid;
        logic [15:0] pin;
        logic        op_valid;
        logic [1:0]  op_code;
        logic        op_done;
        logic [2:0]  exp_state;
        logic [2:0]  exp_err;
        logic        exp_active;
        logic        exp_eject;
        logic        exp_req;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int card, input int acc, input int pv, input int pn, input int ov,
                       input int oc, input int od, input int st, input int er, input int act,
                       input int ej, input int rq, input int ix);
        vec_t v;
        v.card_in = 1'(card); v.acc_num = 4'(acc); v.pin_valid = 1'(pv); v.pin = 16'(pn);
        v.op_valid = 1'(ov); v.op_code = 2'(oc); v.op_done = 1'(od);
        v.exp_state = 3'(st); v.exp_err = 3'(er); v.exp_active = 1'(act);
        v.exp_eject = 1'(ej); v.exp_req = 1'(rq); v.exp_idx = 4'(ix);
        vq.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t run did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic card;
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset.state", 32'(bus.state_out), 32'd0);
        expect_eq("reset.err",   32'(bus.err_code),  32'd0);
        compare_model();
        rst = 1'b0;

        //   card acc pv pin      ov oc od   st er act ej rq idx
        add(1, 3,  0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 0);
        add(1, 3,  0, 0,       0, 0, 0,   2, 0, 0, 0, 0, 2);
        add(1, 3,  1, 'h3456,  0, 0, 0,   3, 0, 0, 0, 0, 2);
        add(1, 3,  0, 0,       0, 0, 0,   4, 0, 1, 0, 0, 2);
        add(1, 3,  0, 0,       1, 1, 0,   5, 0, 1, 0, 1, 2);
        add(1, 3,  0, 0,       0, 0, 0,   5, 0, 1, 0, 1, 2);
        add(1, 3,  0, 0,       0, 0, 1,   4, 0, 1, 0, 0, 2);
        add(1, 3,  0, 0,       1, 3, 0,   6, 0, 0, 1, 0, 2);
        add(0, 3,  0, 0,       0, 0, 0,   0, 0, 0, 0, 0, 2);
        add(1, 12, 0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 2);
        add(1, 12, 0, 0,       0, 0, 0,   6, 1, 0, 1, 0, 2);
        add(1, 12, 0, 0,       0, 0, 0,   6, 1, 0, 1, 0, 2);
        add(0, 12, 0, 0,       0, 0, 0,   0, 1, 0, 0, 0, 2);
        add(1, 5,  0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 2);
        add(1, 5,  0, 0,       0, 0, 0,   2, 0, 0, 0, 0, 4);
        add(1, 5,  1, 'h1111,  0, 0, 0,   3, 0, 0, 0, 0, 4);
        add(1, 5,  0, 0,       0, 0, 0,   2, 2, 0, 0, 0, 4);
        add(1, 5,  1, 'h2222,  0, 0, 0,   3, 2, 0, 0, 0, 4);
        add(1, 5,  0, 0,       0, 0, 0,   2, 2, 0, 0, 0, 4);
        add(1, 5,  1, 'h3333,  0, 0, 0,   3, 2, 0, 0, 0, 4);
        add(1, 5,  0, 0,       0, 0, 0,   6, 3, 0, 1, 0, 4);
        add(0, 5,  0, 0,       0, 0, 0,   0, 3, 0, 0, 0, 4);
        add(1, 5,  0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 4);
        add(1, 5,  0, 0,       0, 0, 0,   6, 3, 0, 1, 0, 4);
        add(0, 5,  0, 0,       0, 0, 0,   0, 3, 0, 0, 0, 4);
        add(1, 9,  0, 0,       0, 0, 0,   1, 0, 0, 0, 0, 4);
        add(1, 9,  0, 0,       0, 0, 0,   6, 1, 0, 1, 0, 4);
        add(0, 9,  0, 0,       0, 0, 0,   0, 1, 0, 0, 0, 4);
        add(0, 9,  1, 'h5555,  0, 0, 1,   0, 1, 0, 0, 0, 4);

        foreach (vq[i]) begin
            drive(vq[i].card_in, vq[i].acc_num, vq[i].pin_valid, vq[i].pin,
                  vq[i].op_valid, vq[i].op_code, vq[i].op_done);
            cycle();
            expect_eq($sformatf("vec%0d.state", i),  32'(bus.state_out),      32'(vq[i].exp_state));
            expect_eq($sformatf("vec%0d.err", i),    32'(bus.err_code),       32'(vq[i].exp_err));
            expect_eq($sformatf("vec%0d.active", i), 32'(bus.session_active), 32'(vq[i].exp_active));
            expect_eq($sformatf("vec%0d.eject", i),  32'(bus.eject),          32'(vq[i].exp_eject));
            expect_eq($sformatf("vec%0d.req", i),    32'(bus.op_req),         32'(vq[i].exp_req));
            expect_eq($sformatf("vec%0d.idx", i),    32'(bus.acc_index),      32'(vq[i].exp_idx));
        end

        // rst clears the lock on account 5; removal in WAIT_PIN then reports ERR_REMOVED.
        drive(1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        reset_pulse();
        drive(1'b1, 4'd5, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle(); cycle();
        expect_eq("unlock.state", 32'(bus.state_out), 32'd2);
        bus.card_in = 1'b0;
        cycle();
        expect_eq("removed.err", 32'(bus.err_code), 32'd5);

        // Inactivity in WAIT_PIN: eject exactly after TIMEOUT_CYCLES idle cycles.
        drive(1'b1, 4'd3, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle(); cycle();
        repeat (TIMEOUT_CYCLES - 1) cycle();
        expect_eq("tmo_wait.before", 32'(bus.state_out), 32'd2);
        cycle();
        expect_eq("tmo_wait.state", 32'(bus.state_out), 32'd6);
        expect_eq("tmo_wait.err",   32'(bus.err_code),  32'd4);
        bus.card_in = 1'b0;
        cycle();

        // MENU: an op_valid just before expiry restarts the idle count.
        drive(1'b1, 4'd3, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle(); cycle();
        bus.pin_valid = 1'b1; bus.pin = 16'h3456;
        cycle();
        bus.pin_valid = 1'b0;
        cycle();
        expect_eq("menu.state", 32'(bus.state_out), 32'd4);
        repeat (TIMEOUT_CYCLES - 2) cycle();
        bus.op_valid = 1'b1; bus.op_code = 2'd0;
        cycle();
        bus.op_valid = 1'b0;
        expect_eq("menu_op.req", 32'(bus.op_req), 32'd1);
        bus.op_done = 1'b1;
        cycle();
        bus.op_done = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) cycle();
        expect_eq("tmo_menu.before", 32'(bus.state_out), 32'd4);
        cycle();
        expect_eq("tmo_menu.err", 32'(bus.err_code), 32'd4);
        bus.card_in = 1'b0;
        cycle();

        // Card pulled during EXEC: op_req held until op_done, then MENU -> IDLE.
        drive(1'b1, 4'd1, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle(); cycle();
        bus.pin_valid = 1'b1; bus.pin = 16'h1234;
        cycle();
        bus.pin_valid = 1'b0;
        cycle();
        bus.op_valid = 1'b1; bus.op_code = 2'd2;
        cycle();
        bus.op_valid = 1'b0;
        bus.card_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            expect_eq("exec_hold.req", 32'(bus.op_req), 32'd1);
        end
        bus.op_done = 1'b1;
        cycle();
        bus.op_done = 1'b0;
        expect_eq("exec_done.req", 32'(bus.op_req), 32'd0);
        cycle();
        expect_eq("exec_removed.err",   32'(bus.err_code),  32'd5);
        expect_eq("exec_removed.state", 32'(bus.state_out), 32'd0);

        // rst in EXEC drops op_req without waiting for a clock edge.
        drive(1'b1, 4'd3, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle(); cycle();
        bus.pin_valid = 1'b1; bus.pin = 16'h3456;
        cycle();
        bus.pin_valid = 1'b0;
        cycle();
        bus.op_valid = 1'b1; bus.op_code = 2'd1;
        cycle();
        bus.op_valid = 1'b0;
        expect_eq("exec.op_sel", 32'(bus.op_sel), 32'd1);
        reset_pulse();
        drive(1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
        cycle();

        // Randomized traffic against the model.
        card = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(99) < 4) card = ~card;
            bus.card_in = card;
            case ($urandom_range(6))
                0: bus.acc_num = 4'd1;
                1: bus.acc_num = 4'd3;
                2: bus.acc_num = 4'd5;
                3: bus.acc_num = 4'd7;
                4: bus.acc_num = 4'd9;
                5: bus.acc_num = 4'd12;
                default: bus.acc_num = 4'($urandom_range(15));
            endcase
            case ($urandom_range(5))
                0: bus.pin = 16'h1234;
                1: bus.pin = 16'h3456;
                2: bus.pin = 16'h5555;
                3: bus.pin = 16'h7777;
                4: bus.pin = 16'h9999;
                default: bus.pin = 16'($urandom);
            endcase
            bus.pin_valid = ($urandom_range(99) < 25);
            bus.op_valid  = ($urandom_range(99) < 20);
            bus.op_code   = 2'($urandom_range(3));
            bus.op_done   = ($urandom_range(99) < 20);
            if ($urandom_range(999) == 0) reset_pulse();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
